// File: rtl/gram_crg_pkg.sv
// -----------------------------------------------------------------------------
// gram_crg_pkg
// Shared definitions for the gram clock-bringup logic.
//   init_state_t    : states of the DDR PHY clock init sequencer
//   DEF_*           : default timing values, in sync-domain clock cycles
//   cnt_width()     : width of a down-counter able to hold the largest timing
//                     value ($clog2(max)+1)
// -----------------------------------------------------------------------------
package gram_crg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DLL_RST,
        ST_DLL_WAIT,
        ST_FREEZE,
        ST_STOP,
        ST_DDR_RST,
        ST_UNSTOP,
        ST_UNFREEZE,
        ST_DONE
    } init_state_t;

    localparam int DEF_LOCK_FILTER = 16;
    localparam int DEF_T_DLL_RST   = 8;
    localparam int DEF_T_SETTLE    = 4;
    localparam int DEF_T_DDR_RST   = 8;
    localparam int DEF_T_DLL_TMO   = 1024;

    // Width needed to hold the largest of the supplied cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/gram_lock_filter.sv
// -----------------------------------------------------------------------------
// gram_lock_filter
// Saturating high-count filter. Counts consecutive cycles with sig_i high,
// clears on any low cycle, saturates at COUNT (never wraps).
// locked_stable is high in a cycle where sig_i is high and this cycle is at
// least the COUNT-th consecutive high cycle, so a consumer registering on it
// acts on exactly the COUNT-th high sample.
// Ports:
//   clk           in  clock
//   rst           in  synchronous active-high reset
//   sig_i         in  signal to filter (already synchronous to clk)
//   locked_stable out sig_i has been high for COUNT consecutive cycles
// -----------------------------------------------------------------------------
module gram_lock_filter #(
    parameter int WIDTH = 5,
    parameter int COUNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic locked_stable
);

    localparam logic [WIDTH-1:0] COUNT_MAX  = WIDTH'(COUNT);
    localparam logic [WIDTH-1:0] COUNT_LAST = WIDTH'(COUNT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!sig_i) begin
            count_d = '0;
        end else if (count_q != COUNT_MAX) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign locked_stable = sig_i && (count_q >= COUNT_LAST);

endmodule

// File: rtl/gram_ddrphy_init_seq.sv
// -----------------------------------------------------------------------------
// gram_ddrphy_init_seq
// ECP5 DDR clocking bring-up sequencer (sync domain). After pll_lock has been
// stable for LOCK_FILTER cycles it walks: DDRDLL reset, wait for DLL lock,
// freeze DLL/DQSBUF updates, stop ECLKSYNC, pulse CLKDIV/DQSBUF reset,
// restart ECLKSYNC, unfreeze, then raises init_done. Losing pll_lock in any
// state restarts the whole sequence from IDLE.
//
// Optional feature macro: GRAM_INIT_TIMEOUT_EN
//   defined   : DLL lock watchdog. T_DLL_TMO cycles in DLL_WAIT without
//               dll_lock sets init_err (sticky) and retries from DLL_RST.
//               init_err clears on entry to DONE or IDLE.
//   undefined : DLL_WAIT waits forever, init_err tied 0.
//
// Ports:
//   clk        in  sync-domain clock
//   rst        in  synchronous active-high reset
//   pll_lock   in  PLL lock (synchronised to clk)
//   dll_lock   in  DDRDLL lock (synchronised to clk)
//   dll_rst    out DDRDLL reset
//   freeze     out DDRDLL/DQSBUF update freeze
//   stop       out ECLKSYNC stop
//   ddr_rst    out CLKDIV/DQSBUF reset
//   init_done  out PHY clocking ready
//   init_err   out DLL watchdog fired
// All outputs are registered decodes of the state held in the previous cycle.
// -----------------------------------------------------------------------------
module gram_ddrphy_init_seq
    import gram_crg_pkg::*;
#(
    parameter int LOCK_FILTER = DEF_LOCK_FILTER,
    parameter int T_DLL_RST   = DEF_T_DLL_RST,
    parameter int T_SETTLE    = DEF_T_SETTLE,
    parameter int T_DDR_RST   = DEF_T_DDR_RST,
    parameter int T_DLL_TMO   = DEF_T_DLL_TMO
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    input  logic dll_lock,
    output logic dll_rst,
    output logic freeze,
    output logic stop,
    output logic ddr_rst,
    output logic init_done,
    output logic init_err
);

    localparam int CW = cnt_width(LOCK_FILTER, T_DLL_RST, T_SETTLE, T_DDR_RST, T_DLL_TMO);

    // Counter reload values: a timed state lasts (load + 1) cycles because
    // the exit happens on the cycle the counter is already zero.
    localparam logic [CW-1:0] LD_DLL_RST = CW'(T_DLL_RST - 1);
    localparam logic [CW-1:0] LD_SETTLE  = CW'(T_SETTLE - 1);
    localparam logic [CW-1:0] LD_DDR_RST = CW'(T_DDR_RST - 1);
`ifdef GRAM_INIT_TIMEOUT_EN
    localparam logic [CW-1:0] LD_DLL_TMO = CW'(T_DLL_TMO - 1);
`else
    localparam logic [CW-1:0] LD_DLL_TMO = '0;
`endif

    init_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic          pll_stable;

    logic dll_rst_q;
    logic freeze_q;
    logic stop_q;
    logic ddr_rst_q;
    logic init_done_q;

`ifdef GRAM_INIT_TIMEOUT_EN
    logic err_q;
    logic init_err_q;
`endif

    // The filter runs continuously: any pll_lock low cycle clears it, so by
    // the time a lock loss has returned the FSM to IDLE it restarts from 0.
    gram_lock_filter #(
        .WIDTH (CW),
        .COUNT (LOCK_FILTER)
    ) u_pll_filter (
        .clk           (clk),
        .rst           (rst),
        .sig_i         (pll_lock),
        .locked_stable (pll_stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dll_rst_q   <= 1'b1;
            freeze_q    <= 1'b0;
            stop_q      <= 1'b0;
            ddr_rst_q   <= 1'b1;
            init_done_q <= 1'b0;
`ifdef GRAM_INIT_TIMEOUT_EN
            err_q       <= 1'b0;
            init_err_q  <= 1'b0;
`endif
        end else begin
            // Output decode of the current state; lands one cycle after it.
            dll_rst_q   <= (state_q == ST_IDLE) || (state_q == ST_DLL_RST);
            ddr_rst_q   <= (state_q inside {ST_IDLE, ST_DLL_RST, ST_DLL_WAIT,
                                            ST_FREEZE, ST_STOP, ST_DDR_RST});
            freeze_q    <= (state_q inside {ST_FREEZE, ST_STOP, ST_DDR_RST, ST_UNSTOP});
            stop_q      <= (state_q inside {ST_STOP, ST_DDR_RST});
            init_done_q <= (state_q == ST_DONE);
`ifdef GRAM_INIT_TIMEOUT_EN
            init_err_q  <= err_q;
`endif

            // Lock loss outranks every other transition.
            if (!pll_lock && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
`ifdef GRAM_INIT_TIMEOUT_EN
                err_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pll_stable) begin
                            state_q <= ST_DLL_RST;
                            cnt_q   <= LD_DLL_RST;
                        end
                    end
                    ST_DLL_RST: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_DLL_WAIT;
                            cnt_q   <= LD_DLL_TMO;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    ST_DLL_WAIT: begin
                        if (dll_lock) begin
                            state_q <= ST_FREEZE;
                            cnt_q   <= LD_SETTLE;
                        end
`ifdef GRAM_INIT_TIMEOUT_EN
                        else if (cnt_q == '0) begin
                            // Watchdog expired: flag it and retry the DLL reset.
                            state_q <= ST_DLL_RST;
                            cnt_q   <= LD_DLL_RST;
                            err_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
`endif
                    end
                    ST_FREEZE: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_STOP;
                            cnt_q   <= LD_SETTLE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    ST_STOP: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_DDR_RST;
                            cnt_q   <= LD_DDR_RST;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    ST_DDR_RST: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_UNSTOP;
                            cnt_q   <= LD_SETTLE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    ST_UNSTOP: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_UNFREEZE;
                            cnt_q   <= LD_SETTLE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    ST_UNFREEZE: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_DONE;
                            cnt_q   <= '0;
`ifdef GRAM_INIT_TIMEOUT_EN
                            err_q   <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    ST_DONE: begin
                        // Terminal: dll_lock is no longer watched here.
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign dll_rst   = dll_rst_q;
    assign freeze    = freeze_q;
    assign stop      = stop_q;
    assign ddr_rst   = ddr_rst_q;
    assign init_done = init_done_q;
`ifdef GRAM_INIT_TIMEOUT_EN
    assign init_err  = init_err_q;
`else
    assign init_err  = 1'b0;
`endif

endmodule

// File: tb/tb_gram_ddrphy_init_seq.sv
// -----------------------------------------------------------------------------
// tb_gram_ddrphy_init_seq
// Bench for gram_ddrphy_init_seq. A phase/age model of the bring-up sequence
// predicts all outputs every cycle; directed scenarios add literal timing pins,
// then a randomized run exercises lock loss, DLL lock jitter and resets.
// -----------------------------------------------------------------------------
module tb_gram_ddrphy_init_seq;

    localparam int LF   = 16;
    localparam int TDR  = 8;
    localparam int TS   = 4;
    localparam int TDDR = 8;
    localparam int TMO  = 32;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;
    logic dll_lock;
    logic dll_rst, freeze, stop, ddr_rst, init_done, init_err;
    logic [4:0] outs;

    assign outs = {dll_rst, ddr_rst, freeze, stop, init_done};

    gram_ddrphy_init_seq #(
        .LOCK_FILTER (LF),
        .T_DLL_RST   (TDR),
        .T_SETTLE    (TS),
        .T_DDR_RST   (TDDR),
        .T_DLL_TMO   (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .dll_lock  (dll_lock),
        .dll_rst   (dll_rst),
        .freeze    (freeze),
        .stop      (stop),
        .ddr_rst   (ddr_rst),
        .init_done (init_done),
        .init_err  (init_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: phase 0..8 = idle, dll reset, dll wait, freeze, stop, ddr reset,
    // unstop, unfreeze, done; age = cycles spent in the phase so far.
    int         m_phase = 0;
    int         m_age   = 0;
    int         m_run   = 0;
    bit         m_err   = 1'b0;
    logic [4:0] exp_o   = 5'b11000;
    bit         exp_err = 1'b0;

    // {dll_rst, ddr_rst, freeze, stop, init_done} wanted while in each phase.
    function automatic logic [4:0] phase_outs(input int p);
        case (p)
            0, 1:    return 5'b11000;
            2:       return 5'b01000;
            3:       return 5'b01100;
            4, 5:    return 5'b01110;
            6:       return 5'b00100;
            7:       return 5'b00000;
            default: return 5'b00001;
        endcase
    endfunction

    function automatic int phase_len(input int p);
        case (p)
            1:       return TDR;
            5:       return TDDR;
            default: return TS;
        endcase
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_phase = 0; m_age = 0; m_run = 0; m_err = 1'b0;
            exp_o = 5'b11000; exp_err = 1'b0;
            return;
        end
        exp_o   = phase_outs(m_phase);
        exp_err = m_err;
        if (!pll_lock) m_run = 0;
        else if (m_run < LF) m_run = m_run + 1;
        if (!pll_lock && m_phase != 0) begin
            m_phase = 0; m_age = 0; m_err = 1'b0;
        end else if (m_phase == 0) begin
            if (m_run >= LF) begin m_phase = 1; m_age = 0; end
        end else if (m_phase == 2) begin
            if (dll_lock) begin
                m_phase = 3; m_age = 0;
            end else begin
                m_age = m_age + 1;
`ifdef GRAM_INIT_TIMEOUT_EN
                if (m_age >= TMO) begin m_phase = 1; m_age = 0; m_err = 1'b1; end
`endif
            end
        end else if (m_phase != 8) begin
            m_age = m_age + 1;
            if (m_age >= phase_len(m_phase)) begin
                m_phase = m_phase + 1;
                m_age = 0;
                if (m_phase == 8) m_err = 1'b0;
            end
        end
    endtask

    // One clock: model advances on the edge, DUT outputs compared half a cycle later.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc = cyc + 1;
        n_tests = n_tests + 1;
        if (outs !== exp_o || init_err !== exp_err) begin
            n_fail = n_fail + 1;
            $display("FAIL cycle %0d outputs: got %b err %b, expected %b err %b",
                     cyc, outs, init_err, exp_o, exp_err);
        end
    endtask

    task automatic pin(input string name, input int act, input int exp);
        n_tests = n_tests + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] %s = %0d ok", name, act);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pll_lock = 1'b0; dll_lock = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic run_until_done(input int bound, output int n);
        n = 0;
        while (n < bound && init_done !== 1'b1) begin
            step();
            n = n + 1;
        end
    endtask

    initial begin
        int e, n;
        int t_dllf, t_frr, t_frf, t_str, t_stf, t_ddrf, t_done;

        // 1: nominal bring-up, dll_lock three cycles into DLL_WAIT
        do_reset();
        pll_lock = 1'b1;
        t_dllf = -1; t_frr = -1; t_frf = -1; t_str = -1; t_stf = -1; t_ddrf = -1; t_done = -1;
        for (e = 1; e <= 60; e++) begin
            if (e == 27) dll_lock = 1'b1;
            step();
            if (t_dllf < 0 && !dll_rst) t_dllf = e;
            if (t_frr < 0 && freeze) t_frr = e;
            if (t_frr >= 0 && t_frf < 0 && !freeze) t_frf = e;
            if (t_str < 0 && stop) t_str = e;
            if (t_str >= 0 && t_stf < 0 && !stop) t_stf = e;
            if (t_ddrf < 0 && !ddr_rst) t_ddrf = e;
            if (t_done < 0 && init_done) t_done = e;
        end
        pin("t1_dll_rst_fall", t_dllf, 25);
        pin("t1_freeze_rise", t_frr, 28);
        pin("t1_stop_rise", t_str, 32);
        pin("t1_ddr_rst_fall", t_ddrf, 44);
        pin("t1_stop_fall", t_stf, 44);
        pin("t1_freeze_fall", t_frf, 48);
        pin("t1_init_done_rise", t_done, 52);

        // 5: dll_lock loss in DONE is ignored
        dll_lock = 1'b0;
        repeat (20) step();
        pin("t5_outs_after_dll_drop", int'(outs), int'(5'b00001));

        // 4: rst in DONE -> reset values next edge, sequence repeats
        dll_lock = 1'b1;
        rst = 1'b1;
        step();
        pin("t4_outs_after_rst", int'(outs), int'(5'b11000));
        rst = 1'b0;
        run_until_done(200, n);
        pin("t4_cycles_to_done", n, 50);

        // 2: pll_lock glitch at filter count 10 restarts the full filter
        do_reset();
        pll_lock = 1'b1; dll_lock = 1'b1;
        repeat (10) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        n = 0;
        while (n < 80 && dll_rst === 1'b1) begin step(); n = n + 1; end
        pin("t2_dll_rst_fall_after_glitch", n, 25);

        // 3: pll_lock lost in STOP, then re-lock
        do_reset();
        pll_lock = 1'b1; dll_lock = 1'b1;
        n = 0;
        while (n < 100 && stop !== 1'b1) begin step(); n = n + 1; end
        pin("t3_stop_reached", int'(stop), 1);
        pll_lock = 1'b0;
        step(); step();
        pin("t3_outs_after_loss", int'(outs), int'(5'b11000));
        pll_lock = 1'b1;
        run_until_done(200, n);
        pin("t3_relock_cycles_to_done", n, 50);

`ifdef GRAM_INIT_TIMEOUT_EN
        // 6: DLL watchdog fires, retries, then completes and clears init_err
        do_reset();
        pll_lock = 1'b1; dll_lock = 1'b0;
        n = 0;
        while (n < 200 && init_err !== 1'b1) begin step(); n = n + 1; end
        pin("t6_init_err_rise", n, 57);
        pin("t6_dll_rst_retry", int'(dll_rst), 1);
        dll_lock = 1'b1;
        run_until_done(200, n);
        pin("t6_done_reached", int'(init_done), 1);
        pin("t6_init_err_cleared", int'(init_err), 0);
`endif

        // Randomized: lock loss, DLL lock jitter and occasional resets
        do_reset();
        pll_lock = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (pll_lock) pll_lock = ($urandom_range(0, 119) != 0);
            else          pll_lock = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 24) == 0) dll_lock = ~dll_lock;
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
